fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction fetch stage sitting directly upstream of instruction_decoder. It owns the program counter, reads 4-bit words from a synchronous-read program memory, and presents one instruction at a time on INSTRUCTION with a one-cycle INSTR_VALID strobe. For LDI it fetches the following word as an immediate operand. It consumes the decoder's RESET_INSTR to restart execution at address 0.

Parameters:
ADDR_WIDTH, 8, program counter and program-memory address width.
INSTR_WIDTH, 4, opcode width; equals the decoder input width.
DATA_WIDTH, 4, immediate width; equals the program-memory word width.

Ports:
CLK  in  1  system clock, all state updates on rising edge.
RESET_N  in  1  synchronous, active-low reset.
RUN  in  1  1 = fetch new instructions; 0 = stop before the next fetch.
PMEM_ADDR  out  ADDR_WIDTH  program-memory read address, equal to the PC register.
PMEM_DATA  in  DATA_WIDTH  program-memory read data, valid one cycle after its address.
RESET_INSTR  in  1  decoder RST indication; honoured only while INSTR_VALID=1.
INSTRUCTION  out  INSTR_WIDTH  instruction register, to the decoder.
INSTR_VALID  out  1  high for exactly one cycle per executed instruction.
IMMEDIATE  out  DATA_WIDTH  LDI operand register, stable from EXEC until the next LDI.
HALTED  out  1  1 while in FETCH with RUN=0.

Behaviour:
- One clock, CLK. Reset is synchronous and active-low, on RESET_N. Reset is sampled on the CLK edge in any state, including mid-LDI, and wins over all other events.
- Reset values: PC=0 (so PMEM_ADDR=0), state=FETCH, INSTRUCTION=4'hC (NOP), INSTR_VALID=0, IMMEDIATE=0. HALTED equals ~RUN.
- States: FETCH, LOAD, IMM, EXEC, one-hot or binary.
- FETCH:
  - PMEM_ADDR=A.
  - RUN=1: PC<=A+1, go to LOAD.
  - RUN=0: hold everything; HALTED=1.
- LOAD:
  - PMEM_DATA=mem[A]; INSTRUCTION<=PMEM_DATA[INSTR_WIDTH-1:0].
  - Opcode 4'hD (LDI): PC<=A+2, go to IMM.
  - Otherwise: go to EXEC, PC unchanged.
- IMM:
  - PMEM_DATA=mem[A+1]; IMMEDIATE<=PMEM_DATA; go to EXEC.
- EXEC:
  - INSTR_VALID=1, driven from the state register.
  - If RESET_INSTR=1, PC<=0.
  - Go to FETCH unconditionally; RUN is not sampled here.
- Latency: 3 cycles per ordinary instruction and 4 per LDI, measured from a FETCH entry to the next FETCH entry. INSTR_VALID is high in the last of those cycles.
- INSTRUCTION and IMMEDIATE hold their values outside EXEC. Downstream gates all clock enables with INSTR_VALID, and RESET_INSTR seen outside EXEC is ignored.
- PC arithmetic is modulo 2^ADDR_WIDTH:
  - A=max wraps to 0.
  - An LDI at max takes its immediate from address 0, and the next fetch is address 1.
- RUN deasserted mid-instruction lets the current instruction complete; the block then halts in FETCH.
- Holding RUN=0 in FETCH causes no memory side effects: the address is stable and no registers change.
- Opcodes 4'hE/4'hF (RST) behave as ordinary instructions in this block. The jump happens only through RESET_INSTR in EXEC. If RESET_INSTR=1 together with LDI, PC still goes to 0.

Decomposition:
- Shared package:
  - opcode constants OP_NOP=4'hC, OP_LDI=4'hD, OP_RST0=4'hE, OP_RST1=4'hF;
  - FSM state encoding;
  - widths INSTR_WIDTH=4 and DATA_WIDTH=4, shared with instruction_decoder.
- One natural sub-module, program_counter. It has synchronous active-low reset, CLR (load 0), INC1 and INC2, with priority reset > CLR > INC2 > INC1.
- The FSM and the IR/IMM registers stay in fetch_sequencer.

Test Plan:
1. Reset with RESET_N=0 for 2 cycles and RUN=1, then release -> PMEM_ADDR=0, INSTRUCTION=4'hC, INSTR_VALID=0 during reset. The first INSTR_VALID pulse comes in the 3rd cycle after release.
2. ROM 0:5, 1:9, 2:3 with RUN=1 -> INSTR_VALID pulses every 3 cycles with INSTRUCTION 5, 9, 3. PMEM_ADDR reads 0, 1, 1, 1, 2... and pulses are exactly 1 cycle wide.
3. ROM 0:D, 1:7, 2:C -> one pulse with INSTRUCTION=D and IMMEDIATE=7 in cycle 4, then a pulse with C. PC goes 0→2, and address 1 is never executed as an opcode.
4. ROM 0:9, 1:E with the bench decoder model driving RESET_INSTR -> after the E pulse PMEM_ADDR=0 and the 9 re-executes. In a variant, RESET_INSTR is forced high outside EXEC, and the PC must be unaffected.
5. RUN dropped during LOAD of an LDI -> the LDI completes (pulse with IMMEDIATE), then HALTED=1 and PMEM_ADDR stable for 10 cycles. RUN re-raised resumes at the next address.
6. ADDR_WIDTH=2 with an LDI at address 3 and ROM[0]=A -> IMMEDIATE=A and the next fetch is address 1. Separately, RESET_N=0 during IMM returns to the reset values on the next edge.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch stage: opcode constants, widths common with
// instruction_decoder, and the fetch FSM state encoding.
package fetch_sequencer_pkg;

  localparam int unsigned INSTR_WIDTH = 4;
  localparam int unsigned DATA_WIDTH  = 4;

  localparam logic [3:0] OP_NOP  = 4'hC;
  localparam logic [3:0] OP_LDI  = 4'hD;
  localparam logic [3:0] OP_RST0 = 4'hE;
  localparam logic [3:0] OP_RST1 = 4'hF;

  typedef enum logic [1:0] {
    StFetch,
    StLoad,
    StImm,
    StExec
  } state_e;

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter with synchronous active-low reset, clear and +1/+2 steps.
// Priority: reset > clr > inc2 > inc1; arithmetic wraps modulo 2^ADDR_WIDTH.
module fetch_sequencer_program_counter #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  inc1,
  input  logic                  inc2,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else if (clr) begin
      pc_q <= '0;
    end else if (inc2) begin
      pc_q <= pc_q + ADDR_WIDTH'(2);
    end else if (inc1) begin
      pc_q <= pc_q + ADDR_WIDTH'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: walks the program counter through a synchronous-read
// program memory and hands one instruction (plus LDI operand) to the decoder.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = fetch_sequencer_pkg::INSTR_WIDTH,
  parameter int unsigned DATA_WIDTH  = fetch_sequencer_pkg::DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  output logic [ADDR_WIDTH-1:0]  pmem_addr,
  input  logic [DATA_WIDTH-1:0]  pmem_data,
  input  logic                   reset_instr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [DATA_WIDTH-1:0]  immediate,
  output logic                   halted
);

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0]  imm_q, imm_d;
  logic                   pc_clr;
  logic                   pc_inc1;
  logic [ADDR_WIDTH-1:0]  pc;

  // LDI reaches A+2 as two single steps (FETCH, then LOAD) so that the operand
  // address A+1 is already on the bus while the opcode is being decoded.
  fetch_sequencer_program_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (pc_clr),
    .inc1   (pc_inc1),
    .inc2   (1'b0),
    .pc     (pc)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    pc_clr  = 1'b0;
    pc_inc1 = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (run) begin
          pc_inc1 = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        instr_d = pmem_data[INSTR_WIDTH-1:0];
        if (pmem_data[INSTR_WIDTH-1:0] == INSTR_WIDTH'(OP_LDI)) begin
          pc_inc1 = 1'b1;
          state_d = StImm;
        end else begin
          state_d = StExec;
        end
      end
      StImm: begin
        imm_d   = pmem_data;
        state_d = StExec;
      end
      StExec: begin
        // RUN is deliberately not sampled here; the halt happens in FETCH.
        pc_clr  = reset_instr;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StFetch;
      instr_q <= INSTR_WIDTH'(OP_NOP);
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
    end
  end

  assign pmem_addr   = pc;
  assign instruction = instr_q;
  assign immediate   = imm_q;
  assign instr_valid = (state_q == StExec);
  assign halted      = (state_q == StFetch) && !run;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: instruction-level reference model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_fetch_sequencer;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic [7:0] pmem_addr;
  logic [3:0] pmem_data;
  logic       reset_instr;
  logic [3:0] instruction;
  logic       instr_valid;
  logic [3:0] immediate;
  logic       halted;

  logic       dec_en;
  logic       force_rst;
  logic       chk_en;

  logic       reset2_n;
  logic [1:0] pmem2_addr;
  logic [3:0] pmem2_data;
  logic [3:0] instruction2;
  logic       instr_valid2;
  logic [3:0] immediate2;
  logic       halted2;

  logic [3:0] mem  [0:255];
  logic [3:0] mem2 [0:3];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] addr_log   [0:1023];
  logic       valid_log  [0:1023];
  logic [3:0] instr_log  [0:1023];
  logic [3:0] imm_log    [0:1023];
  logic       halted_log [0:1023];
  logic [1:0] addr2_log  [0:1023];
  logic       valid2_log [0:1023];
  logic [3:0] instr2_log [0:1023];
  logic [3:0] imm2_log   [0:1023];

  fetch_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .pmem_addr  (pmem_addr),
    .pmem_data  (pmem_data),
    .reset_instr(reset_instr),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .immediate  (immediate),
    .halted     (halted)
  );

  fetch_sequencer #(
    .ADDR_WIDTH(2)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset2_n),
    .run        (1'b1),
    .pmem_addr  (pmem2_addr),
    .pmem_data  (pmem2_data),
    .reset_instr(1'b0),
    .instruction(instruction2),
    .instr_valid(instr_valid2),
    .immediate  (immediate2),
    .halted     (halted2)
  );

  // Decoder stand-in: RST opcodes assert reset_instr while valid; the forced
  // variant drives it high only outside EXEC, where it must be ignored.
  assign reset_instr = dec_en ? (instr_valid && (instruction[3:1] == 3'b111))
                              : (force_rst && !instr_valid);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous-read program memories.
  initial forever begin
    @(posedge clk);
    pmem_data  <= mem[pmem_addr];
    pmem2_data <= mem2[pmem2_addr];
  end

  // Reference model: one expected-output record per cycle, generated an
  // instruction at a time from the memory image.
  typedef struct {
    logic [7:0] addr;
    logic       valid;
    logic [3:0] instr;
    logic [3:0] imm;
    logic       fetch;
    logic [7:0] nxt;
  } exp_t;

  exp_t       cur;
  exp_t       pend [$];
  logic [7:0] m_pc;
  logic [3:0] m_instr;
  logic [3:0] m_imm;

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{addr: m_pc, valid: 1'b0, instr: m_instr, imm: m_imm, fetch: 1'b1, nxt: 8'd0};
    return e;
  endfunction

  task automatic plan();
    logic [7:0] a;
    logic [3:0] op;
    a  = m_pc;
    op = mem[a];
    pend.push_back('{addr: a + 8'd1, valid: 1'b0, instr: m_instr, imm: m_imm,
                     fetch: 1'b0, nxt: 8'd0});
    if (op == 4'hD) begin
      pend.push_back('{addr: a + 8'd2, valid: 1'b0, instr: op, imm: m_imm,
                       fetch: 1'b0, nxt: 8'd0});
      pend.push_back('{addr: a + 8'd2, valid: 1'b1, instr: op, imm: mem[8'(a + 8'd1)],
                       fetch: 1'b0, nxt: a + 8'd2});
    end else begin
      pend.push_back('{addr: a + 8'd1, valid: 1'b1, instr: op, imm: m_imm,
                       fetch: 1'b0, nxt: a + 8'd1});
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_pc    = 8'd0;
      m_instr = 4'hC;
      m_imm   = 4'h0;
      pend.delete();
      cur = idle_exp();
    end else if (cur.fetch) begin
      if (run) begin
        plan();
        cur = pend.pop_front();
      end else begin
        cur = idle_exp();
      end
    end else begin
      if (cur.valid) m_pc = reset_instr ? 8'd0 : cur.nxt;
      if (pend.size() > 0) cur = pend.pop_front();
      else cur = idle_exp();
    end
    m_instr = cur.instr;
    m_imm   = cur.imm;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, and logging for directed checks.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("pmem_addr",   32'(pmem_addr),   32'(cur.addr));
      chk("instr_valid", 32'(instr_valid), 32'(cur.valid));
      chk("instruction", 32'(instruction), 32'(cur.instr));
      chk("immediate",   32'(immediate),   32'(cur.imm));
      chk("halted",      32'(halted),      32'(cur.fetch && !run));
    end
    if (cyc < 1024) begin
      addr_log[cyc]   = pmem_addr;
      valid_log[cyc]  = instr_valid;
      instr_log[cyc]  = instruction;
      imm_log[cyc]    = immediate;
      halted_log[cyc] = halted;
      addr2_log[cyc]  = pmem2_addr;
      valid2_log[cyc] = instr_valid2;
      instr2_log[cyc] = instruction2;
      imm2_log[cyc]   = immediate2;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Two reset cycles; returns the index of the first cycle after release.
  task automatic do_reset(output int r);
    reset_n = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    reset_n = 1'b1;
    r = cyc;
  endtask

  task automatic load_rom(input logic [3:0] w0, input logic [3:0] w1,
                          input logic [3:0] w2, input logic [3:0] w3);
    for (int i = 0; i < 256; i++) mem[i] = 4'h0;
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    mem[3] = w3;
  endtask

  int r;

  initial begin
    reset_n   = 1'b0;
    reset2_n  = 1'b0;
    run       = 1'b1;
    dec_en    = 1'b1;
    force_rst = 1'b0;
    chk_en    = 1'b0;
    pmem_data  = 4'h0;
    pmem2_data = 4'h0;

    // Reset values, then three ordinary instructions.
    load_rom(4'h5, 4'h9, 4'h3, 4'h0);
    do_reset(r);
    tick(9);
    chk("rst_addr",   32'(addr_log[r-1]),  32'h0);
    chk("rst_instr",  32'(instr_log[r-1]), 32'hC);
    chk("rst_valid",  32'(valid_log[r-1]), 32'h0);
    chk("rst_imm",    32'(imm_log[r-1]),   32'h0);
    chk("seq_addr0",  32'(addr_log[r]),    32'h0);
    chk("seq_addr1",  32'(addr_log[r+1]),  32'h1);
    chk("seq_addr2",  32'(addr_log[r+2]),  32'h1);
    chk("seq_addr3",  32'(addr_log[r+3]),  32'h1);
    chk("seq_addr4",  32'(addr_log[r+4]),  32'h2);
    chk("seq_nopre",  32'(valid_log[r+1]), 32'h0);
    chk("seq_v0",     32'(valid_log[r+2]), 32'h1);
    chk("seq_i0",     32'(instr_log[r+2]), 32'h5);
    chk("seq_width",  32'(valid_log[r+3]), 32'h0);
    chk("seq_v1",     32'(valid_log[r+5]), 32'h1);
    chk("seq_i1",     32'(instr_log[r+5]), 32'h9);
    chk("seq_v2",     32'(valid_log[r+8]), 32'h1);
    chk("seq_i2",     32'(instr_log[r+8]), 32'h3);

    // LDI fetches its operand and skips over it.
    load_rom(4'hD, 4'h7, 4'hC, 4'h0);
    do_reset(r);
    tick(8);
    chk("ldi_immaddr", 32'(addr_log[r+2]),  32'h2);
    chk("ldi_early",   32'(valid_log[r+2]), 32'h0);
    chk("ldi_v",       32'(valid_log[r+3]), 32'h1);
    chk("ldi_i",       32'(instr_log[r+3]), 32'hD);
    chk("ldi_imm",     32'(imm_log[r+3]),   32'h7);
    chk("ldi_next_v",  32'(valid_log[r+6]), 32'h1);
    chk("ldi_next_i",  32'(instr_log[r+6]), 32'hC);
    chk("ldi_immhold", 32'(imm_log[r+6]),   32'h7);

    // RST opcode with decoder feedback restarts at address 0.
    load_rom(4'h9, 4'hE, 4'h3, 4'h0);
    do_reset(r);
    tick(10);
    chk("rst_op_v",    32'(valid_log[r+5]), 32'h1);
    chk("rst_op_i",    32'(instr_log[r+5]), 32'hE);
    chk("rst_jump",    32'(addr_log[r+6]),  32'h0);
    chk("rst_again_v", 32'(valid_log[r+8]), 32'h1);
    chk("rst_again_i", 32'(instr_log[r+8]), 32'h9);

    // reset_instr outside EXEC has no effect on the PC.
    load_rom(4'h5, 4'h9, 4'h3, 4'h0);
    dec_en    = 1'b0;
    force_rst = 1'b1;
    do_reset(r);
    tick(10);
    chk("frc_addr", 32'(addr_log[r+6]),  32'h2);
    chk("frc_i1",   32'(instr_log[r+5]), 32'h9);
    chk("frc_i2",   32'(instr_log[r+8]), 32'h3);
    force_rst = 1'b0;
    dec_en    = 1'b1;

    // RUN dropped during LOAD of an LDI: it completes, then halts in FETCH.
    load_rom(4'hD, 4'h6, 4'h5, 4'h0);
    do_reset(r);
    tick(1);
    run = 1'b0;
    tick(13);
    chk("halt_ldi_v",   32'(valid_log[r+3]), 32'h1);
    chk("halt_ldi_imm", 32'(imm_log[r+3]),   32'h6);
    for (int k = 4; k < 14; k++) begin
      chk("halt_flag", 32'(halted_log[r+k]), 32'h1);
      chk("halt_addr", 32'(addr_log[r+k]),   32'h2);
      chk("halt_nov",  32'(valid_log[r+k]),  32'h0);
    end
    run = 1'b1;
    tick(4);
    chk("resume_v",   32'(valid_log[r+16]), 32'h1);
    chk("resume_i",   32'(instr_log[r+16]), 32'h5);
    chk("resume_imm", 32'(imm_log[r+16]),   32'h6);

    // Reset asserted during the IMM cycle of a second LDI.
    load_rom(4'hD, 4'h7, 4'hD, 4'h9);
    do_reset(r);
    tick(6);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(3);
    chk("imrst_pre_imm", 32'(imm_log[r+6]),   32'h7);
    chk("imrst_pre_i",   32'(instr_log[r+6]), 32'hD);
    chk("imrst_addr",    32'(addr_log[r+7]),  32'h0);
    chk("imrst_instr",   32'(instr_log[r+7]), 32'hC);
    chk("imrst_imm",     32'(imm_log[r+7]),   32'h0);
    chk("imrst_valid",   32'(valid_log[r+7]), 32'h0);

    // 2-bit address space: LDI at the top address wraps for its operand.
    mem2[0] = 4'hA;
    mem2[1] = 4'h0;
    mem2[2] = 4'h0;
    mem2[3] = 4'hD;
    reset2_n = 1'b1;
    r = cyc;
    tick(15);
    chk("w_first_v",   32'(valid2_log[r+2]),  32'h1);
    chk("w_first_i",   32'(instr2_log[r+2]),  32'hA);
    chk("w_load_addr", 32'(addr2_log[r+10]),  32'h0);
    chk("w_imm_addr",  32'(addr2_log[r+11]),  32'h1);
    chk("w_ldi_v",     32'(valid2_log[r+12]), 32'h1);
    chk("w_ldi_i",     32'(instr2_log[r+12]), 32'hD);
    chk("w_ldi_imm",   32'(imm2_log[r+12]),   32'hA);
    chk("w_next_addr", 32'(addr2_log[r+13]),  32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
